// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg
//   Shared definitions for the boot-time program loader: loader state
//   encoding, frame constants and the image-size check used on the header.
package mem_loader_pkg;

  localparam int CNT_WIDTH      = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

  // True when an image of n words fits a memory of 2**aw words.
  // Memories of 2**CNT_WIDTH words or more can hold any count the header
  // can express, so the comparison is skipped there.
  function automatic logic count_fits(input logic [CNT_WIDTH-1:0] n,
                                      input int unsigned          aw);
    logic [CNT_WIDTH:0] cap;
    if (aw >= CNT_WIDTH) return 1'b1;
    cap = (CNT_WIDTH+1)'(1) << aw;
    return ({1'b0, n} <= cap);
  endfunction

endpackage

// File: rtl/mem_loader_byte_packer.sv
// byte_packer
//   Collects payload bytes into 32-bit big-endian words. The first byte of
//   a word lands in bits 31:24, the fourth in bits 7:0.
//
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     clear        drop any partial word and restart at byte 0
//     byte_valid   a payload byte is accepted this cycle
//     byte_data    the accepted byte
//     word_valid   combinational: this cycle's byte completes a word
//     word_data    the completed word (valid with word_valid)
module byte_packer
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  // Only the first three bytes of a word need storage: the fourth is taken
  // straight from the input so the word is complete in its accept cycle and
  // the top level can register the write without a stall.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_valid) begin
      shift_d = {shift_q[15:0], byte_data};
      idx_d   = idx_q + 2'd1;
    end
  end

  assign word_valid = byte_valid && !clear &&
                      (idx_q == 2'(BYTES_PER_WORD - 1));
  assign word_data  = {shift_q, byte_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader
//   Boot-time program loader for the single-cycle MIPS CPU. Receives a
//   framed byte stream (16-bit big-endian word count, 4*N payload bytes,
//   XOR checksum), writes the packed words to memory from word 0 upward and
//   keeps the CPU in reset until a checksum-verified image is in place.
//
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     in_data      stream byte
//     in_valid     in_data valid; a byte moves when in_valid && in_ready
//     in_ready     loader can take a byte (decoded from the state register)
//     reload       request a new image; only acted on in DONE or ERR
//     mem_we       one-cycle write strobe
//     mem_addr     word address of the write (held until the next write)
//     mem_wdata    write data (held until the next write)
//     cpu_hold     CPU reset hold, released only by a good image
//     done         image loaded and checksum correct
//     error        framing or checksum failure, sticky until reload/reset
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  state_e                state_q, state_d;
  logic [7:0]            cnt_hi_q, cnt_hi_d;
  logic [CNT_WIDTH-1:0]  words_left_q, words_left_d;
  logic [7:0]            xor_q, xor_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic                  restart;
  logic                  pack_valid;
  logic                  word_valid;
  logic [31:0]           word_data;
  logic [CNT_WIDTH-1:0]  hdr_count;

  assign in_ready   = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                      (state_q == DATA)   || (state_q == CHK);
  assign accept     = in_valid && in_ready;
  assign restart    = reload && ((state_q == DONE) || (state_q == ERR));
  assign pack_valid = accept && (state_q == DATA);
  // Full count as it becomes known in the CNT_LO cycle.
  assign hdr_count  = {cnt_hi_q, in_data};

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_hi_d     = cnt_hi_q;
    words_left_d = words_left_q;
    xor_d        = xor_q;
    wr_addr_d    = wr_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    error_d      = error_q;

    unique case (state_q)
      HDR_HI: begin
        if (accept) begin
          cnt_hi_d = in_data;
          state_d  = HDR_LO;
        end
      end

      HDR_LO: begin
        if (accept) begin
          words_left_d = hdr_count;
          if (!count_fits(hdr_count, ADDR_WIDTH)) begin
            state_d = ERR;
            error_d = 1'b1;
          end else if (hdr_count == '0) begin
            state_d = CHK;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          xor_d = xor_q ^ in_data;
          if (word_valid) begin
            mem_we_d     = 1'b1;
            mem_addr_d   = wr_addr_q;
            mem_wdata_d  = word_data;
            wr_addr_d    = wr_addr_q + 1'b1;
            words_left_d = words_left_q - 1'b1;
            if (words_left_q == CNT_WIDTH'(1)) state_d = CHK;
          end
        end
      end

      CHK: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end

      DONE, ERR: begin
        // mem_addr/mem_wdata keep the last write; everything that tracks
        // frame progress starts over.
        if (restart) begin
          state_d      = HDR_HI;
          done_d       = 1'b0;
          error_d      = 1'b0;
          cpu_hold_d   = 1'b1;
          xor_d        = '0;
          wr_addr_d    = '0;
          words_left_d = '0;
          cnt_hi_d     = '0;
        end
      end

      default: state_d = HDR_HI;
    endcase
  end

  // Stage boundary: accepted byte -> registered state and write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HDR_HI;
      cnt_hi_q     <= '0;
      words_left_q <= '0;
      xor_q        <= '0;
      wr_addr_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_hi_q     <= cnt_hi_d;
      words_left_q <= words_left_d;
      xor_q        <= xor_d;
      wr_addr_q    <= wr_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_mem_loader.sv
`timescale 1ns/1ps
module tb_mem_loader;

  localparam int AW  = 10;
  localparam int SAW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          reload = 1'b0;
  logic          in_ready, mem_we, cpu_hold, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  logic [7:0]     s_data = 8'h00;
  logic           s_valid = 1'b0;
  logic           s_reload = 1'b0;
  logic           s_ready, s_we, s_hold, s_done, s_error;
  logic [SAW-1:0] s_addr;
  logic [31:0]    s_wdata;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  // Small-memory instance (4 words) for the image-size boundary.
  mem_loader #(.ADDR_WIDTH(SAW)) dut_s (
    .clk(clk), .reset(reset), .in_data(s_data), .in_valid(s_valid),
    .in_ready(s_ready), .reload(s_reload), .mem_we(s_we),
    .mem_addr(s_addr), .mem_wdata(s_wdata), .cpu_hold(s_hold),
    .done(s_done), .error(s_error)
  );

  int tests = 0;
  int fails = 0;

  // Write monitor: one cycle counter, every write strobe logged with the
  // cycle it was seen in.
  int          ncyc = 0;
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          s_wr_cnt = 0;
  int          s_last_addr = 0;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (mem_we === 1'b1) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(ncyc);
    end
    if (s_we === 1'b1) begin
      s_wr_cnt    = s_wr_cnt + 1;
      s_last_addr = int'(s_addr);
    end
  end

  // Reference image: the words the frame carries, and the cycle each byte
  // of the frame was presented on the bus.
  logic [31:0] exp_words[$];
  int          pres_cyc[$];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] d, input logic rl);
    if (sel) begin
      s_valid = v; s_data = d; s_reload = rl;
    end else begin
      in_valid = v; in_data = d; reload = rl;
    end
  endtask

  function automatic int gapn(input int pct);
    if (pct < 0) return 1;
    if (int'($urandom_range(0, 99)) < pct) return int'($urandom_range(1, 2));
    return 0;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte was taken.
  task automatic send_byte(input bit sel, input logic [7:0] b, input int gaps, input logic rl);
    for (int g = 0; g < gaps; g++) begin
      drive(sel, 1'b0, 8'($urandom), 1'b0);
      @(posedge clk); #1;
    end
    drive(sel, 1'b1, b, rl);
    pres_cyc.push_back(ncyc);
    chk1("in_ready while sending", sel ? s_ready : in_ready, 1'b1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 8'h00, 1'b0);
  endtask

  // Builds the frame for exp_words from the framing rules; the checksum is
  // the XOR of the payload bytes, flipped in bit 0 when bad is set.
  task automatic send_frame(input bit sel, input bit bad, input int gap_pct, input int rl_pct);
    logic [7:0] x;
    logic [7:0] b;
    int         n;
    x = 8'h00;
    n = exp_words.size();
    pres_cyc.delete();
    send_byte(sel, 8'(n >> 8), gapn(gap_pct), 1'b0);
    send_byte(sel, 8'(n), gapn(gap_pct), 1'b0);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(exp_words[i] >> (24 - 8 * k));
        x = x ^ b;
        send_byte(sel, b, gapn(gap_pct), 1'(int'($urandom_range(0, 99)) < rl_pct));
      end
    end
    chk1("done before CHK", sel ? s_done : done, 1'b0);
    chk1("cpu_hold before CHK", sel ? s_hold : cpu_hold, 1'b1);
    send_byte(sel, x ^ {7'd0, bad}, gapn(gap_pct), 1'b0);
  endtask

  task automatic clear_mon();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
  endtask

  task automatic check_writes(input string tag);
    int m;
    chk32({tag, " write count"}, 32'(wr_data.size()), 32'(exp_words.size()));
    m = (wr_data.size() < exp_words.size()) ? wr_data.size() : exp_words.size();
    for (int i = 0; i < m; i++) begin
      chk32({tag, " addr"}, 32'(wr_addr[i]), 32'(i));
      chk32({tag, " data"}, wr_data[i], exp_words[i]);
      // Strobe appears the cycle after the word's 4th byte is accepted.
      chk32({tag, " write cycle"}, 32'(wr_cyc[i]), 32'(pres_cyc[4 * i + 5] + 2));
    end
  endtask

  task automatic check_end(input string tag, input logic bad);
    chk1({tag, " done"}, done, !bad);
    chk1({tag, " error"}, error, bad);
    chk1({tag, " cpu_hold"}, cpu_hold, bad);
    chk1({tag, " in_ready"}, in_ready, 1'b0);
    chk1({tag, " mem_we idle"}, mem_we, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk1({tag, " in_ready"}, in_ready, 1'b1);
    chk1({tag, " mem_we"}, mem_we, 1'b0);
    chk32({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk32({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk1({tag, " cpu_hold"}, cpu_hold, 1'b1);
    chk1({tag, " done"}, done, 1'b0);
    chk1({tag, " error"}, error, 1'b0);
  endtask

  task automatic idle_junk(input bit sel, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      drive(sel, 1'b1, 8'($urandom), 1'b0);
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reload(input bit sel);
    drive(sel, 1'b0, 8'h00, 1'b1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 8'h00, 1'b0);
    chk1("reload done clear", sel ? s_done : done, 1'b0);
    chk1("reload error clear", sel ? s_error : error, 1'b0);
    chk1("reload cpu_hold", sel ? s_hold : cpu_hold, 1'b1);
    chk1("reload in_ready", sel ? s_ready : in_ready, 1'b1);
  endtask

  initial begin
    int n;
    bit bad;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic two-word load
    clear_mon();
    exp_words = '{32'hDEADBEEF, 32'h0000002A};
    send_frame(1'b0, 1'b0, 0, 0);
    check_writes("basic");
    check_end("basic", 1'b0);
    chk32("basic held addr", 32'(mem_addr), 32'd1);
    chk32("basic held data", mem_wdata, 32'h0000002A);
    do_reload(1'b0);

    // Same image, corrupted checksum; bytes offered in ERR are ignored
    clear_mon();
    send_frame(1'b0, 1'b1, 0, 0);
    check_writes("badchk");
    check_end("badchk", 1'b1);
    idle_junk(1'b0, 3);
    chk1("err sticky", error, 1'b1);
    chk1("err cpu_hold", cpu_hold, 1'b1);
    chk32("err no extra writes", 32'(wr_data.size()), 32'd2);
    do_reload(1'b0);

    // Empty image with in_valid low every other cycle
    clear_mon();
    exp_words.delete();
    send_frame(1'b0, 1'b0, -1, 0);
    check_writes("empty");
    check_end("empty", 1'b0);
    do_reload(1'b0);

    // One-word image with reload pulsed on every payload byte
    clear_mon();
    exp_words = '{32'h12345678};
    send_frame(1'b0, 1'b0, 0, 100);
    check_writes("reload_in_data");
    check_end("reload_in_data", 1'b0);
    do_reload(1'b0);

    // Randomized images, gaps, checksum faults and stray reloads
    for (int f = 0; f < 10; f++) begin
      clear_mon();
      exp_words.delete();
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      bad = ($urandom_range(0, 2) == 0);
      send_frame(1'b0, bad, int'($urandom_range(0, 1)) * 40, 25);
      check_writes("random");
      check_end("random", bad);
      idle_junk(1'b0, 2);
      chk1("random state held", done, !bad);
      do_reload(1'b0);
    end

    // Reset in the middle of the payload
    clear_mon();
    exp_words = '{32'hA1B2C3D4, 32'h55667788, 32'h99AABBCC};
    pres_cyc.delete();
    send_byte(1'b0, 8'h00, 0, 1'b0);
    send_byte(1'b0, 8'h03, 0, 1'b0);
    for (int k = 0; k < 6; k++)
      send_byte(1'b0, 8'(exp_words[k / 4] >> (24 - 8 * (k % 4))), 0, 1'b0);
    chk32("midreset writes before", 32'(wr_data.size()), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    clear_mon();
    exp_words = '{$urandom};
    send_frame(1'b0, 1'b0, 0, 0);
    check_writes("after_reset");
    check_end("after_reset", 1'b0);

    // Small memory: five words rejected at the header, four accepted
    s_wr_cnt = 0;
    send_byte(1'b1, 8'h00, 0, 1'b0);
    send_byte(1'b1, 8'h05, 0, 1'b0);
    chk1("oversize error", s_error, 1'b1);
    chk1("oversize in_ready", s_ready, 1'b0);
    chk1("oversize done", s_done, 1'b0);
    chk1("oversize cpu_hold", s_hold, 1'b1);
    idle_junk(1'b1, 4);
    chk32("oversize no writes", 32'(s_wr_cnt), 32'd0);
    do_reload(1'b1);
    exp_words.delete();
    for (int i = 0; i < 4; i++) exp_words.push_back($urandom);
    send_frame(1'b1, 1'b0, 20, 0);
    chk1("fullsize done", s_done, 1'b1);
    chk1("fullsize error", s_error, 1'b0);
    chk32("fullsize writes", 32'(s_wr_cnt), 32'd4);
    chk32("fullsize last addr", 32'(s_last_addr), 32'd3);
    chk32("fullsize last data", s_wdata, exp_words[3]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
